// File: rtl/pisa_bus_pkg.sv
// Shared definitions for the system memory bus: arbiter state encoding and
// memory operation codes.
package pisa_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RESPOND = 2'd2
  } arb_state_t;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first set request bit starting
// one position after the last grant, wrapping around.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  // Rotating scan; the port granted last ends up with the lowest priority.
  always_comb begin : pick
    int   cand;
    logic hit;
    cand        = 0;
    hit         = 1'b0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand        = (int'(last_grant) + 1 + i) % NUM_REQ;
      hit         = req[cand] && !grant_valid;
      grant_idx   = hit ? IDX_W'(cand) : grant_idx;
      grant_valid = grant_valid || req[cand];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the single-port memory bus between NUM_REQ
// requesters; sequences one access at a time and pulses a per-port response.
module mem_bus_arbiter
  import pisa_bus_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data_out,
  output logic                        mem_write_enable,
  input  logic [DATA_W-1:0]           mem_data_in,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t          state_r;
  arb_state_t          state_s;
  logic                grant_valid_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                accept_s;
  logic                last_access_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic [NUM_REQ-1:0]  grant_onehot_s;

  logic [IDX_W-1:0]    last_grant_r;
  logic [IDX_W-1:0]    grant_id_r;
  logic                op_r;
  logic [3:0]          cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r;
  logic [NUM_REQ-1:0]  rsp_valid_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                busy_r;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req         (req_valid),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // The picker only reports a set bit, so ready & valid collapses to this.
  assign accept_s      = (state_r == ARB_IDLE) && grant_valid_s;
  assign last_access_s = (state_r == ARB_ACCESS) &&
                         ((op_r == MEM_OP_WRITE) || (cnt_r == 4'd1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (accept_s) begin
          state_s = ARB_ACCESS;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_ACCESS: begin
        if (last_access_s) begin
          state_s = ARB_RESPOND;
        end else begin
          state_s = ARB_ACCESS;
        end
      end
      ARB_RESPOND: state_s = ARB_IDLE;
      default:     state_s = ARB_IDLE;
    endcase
  end

  // Ready goes only to the picked port and only while idle.
  always_comb begin
    req_ready_s = '0;
    if (accept_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // One-hot of the port currently being served, for the response pulse.
  always_comb begin
    grant_onehot_s             = '0;
    grant_onehot_s[grant_id_r] = 1'b1;
  end

  // Request latch, latency counter, write strobe and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      grant_id_r   <= '0;
      op_r         <= MEM_OP_READ;
      cnt_r        <= 4'd0;
      addr_r       <= '0;
      wdata_r      <= '0;
      we_r         <= 1'b0;
      rsp_valid_r  <= '0;
      rdata_r      <= '0;
      busy_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r       <= req_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
        op_r         <= req_write[grant_idx_s];
        grant_id_r   <= grant_idx_s;
        last_grant_r <= grant_idx_s;
        cnt_r        <= 4'(MEM_LATENCY);
        we_r         <= (req_write[grant_idx_s] == MEM_OP_WRITE);
        if (req_write[grant_idx_s] == MEM_OP_WRITE) begin
          wdata_r <= req_wdata[int'(grant_idx_s)*DATA_W +: DATA_W];
        end else begin
          wdata_r <= wdata_r;
        end
      end else begin
        if (state_r == ARB_ACCESS) begin
          cnt_r <= cnt_r - 4'd1;
        end else begin
          cnt_r <= cnt_r;
        end
        if (last_access_s) begin
          we_r <= 1'b0;
        end else begin
          we_r <= we_r;
        end
      end
      // Data is sampled on the final access cycle only; writes leave it alone.
      if (last_access_s && (op_r == MEM_OP_READ)) begin
        rdata_r <= mem_data_in;
      end else begin
        rdata_r <= rdata_r;
      end
      rsp_valid_r <= last_access_s ? grant_onehot_s : '0;
      busy_r      <= (state_s != ARB_IDLE);
    end
  end

  assign req_ready        = req_ready_s;
  assign rsp_valid        = rsp_valid_r;
  assign rsp_rdata        = rdata_r;
  assign mem_address      = addr_r;
  assign mem_data_out     = wdata_r;
  assign mem_write_enable = we_r;
  assign busy             = busy_r;
  assign grant_id         = grant_id_r;

endmodule
